// File: rtl/rv_alu_pkg.sv
// ----------------------------------------------------------------------------
// rv_alu_pkg
// Definitions shared by the ID/EX issue stage and its decoder:
//   - XLEN            datapath width of the operands and immediate
//   - OP_R/OP_I/OP_BR the RV32 opcodes the stage understands
//   - ALU_*           6-bit ALU control codes driven to the ALU alu_cnt port
//   - instr_class_e   coarse instruction class used to pick immediate/rd
//   - idex_t          the contents of the ID/EX pipeline register
// ----------------------------------------------------------------------------
package rv_alu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Zero is reserved to mean "illegal instruction"
    localparam logic [5:0] ALU_ILLEGAL = 6'b000000;

    localparam logic [5:0] ALU_ADD  = 6'b000001;
    localparam logic [5:0] ALU_SUB  = 6'b000010;
    localparam logic [5:0] ALU_SLL  = 6'b000011;
    localparam logic [5:0] ALU_SLT  = 6'b000100;
    localparam logic [5:0] ALU_XOR  = 6'b000110;
    localparam logic [5:0] ALU_SRL  = 6'b000111;
    localparam logic [5:0] ALU_OR   = 6'b001000;
    localparam logic [5:0] ALU_AND  = 6'b001001;

    localparam logic [5:0] ALU_ADDI = 6'b001011;
    localparam logic [5:0] ALU_SLLI = 6'b001100;
    localparam logic [5:0] ALU_SLTI = 6'b001101;
    localparam logic [5:0] ALU_ANDI = 6'b001110;
    localparam logic [5:0] ALU_XORI = 6'b001111;
    localparam logic [5:0] ALU_SRLI = 6'b010000;
    localparam logic [5:0] ALU_ORI  = 6'b010001;

    localparam logic [5:0] ALU_BEQ  = 6'b011011;
    localparam logic [5:0] ALU_BNE  = 6'b011100;
    localparam logic [5:0] ALU_BLT  = 6'b011101;
    localparam logic [5:0] ALU_BGE  = 6'b011110;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_I,
        CLS_BR,
        CLS_ILL
    } instr_class_e;

    typedef struct packed {
        logic [5:0]      aluCnt;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [XLEN-1:0] imm;
        logic [3:0]      shamt;
        logic [4:0]      rd;
        logic            illegal;
    } idex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every signal of the ID/EX stage except clock and reset.
//   Upstream   : in_valid, in_ready, in_instr, flush
//   Reg file   : rs1_addr, rs2_addr, rs1_data, rs2_data
//   Downstream : out_valid, out_ready, out_alu_cnt, out_r1, out_r2, out_imm,
//                out_shamt, out_rd, out_illegal
//   Status     : ill_count
// Modports:
//   slave  - the stage itself
//   master - whatever surrounds the stage (fetch, reg file, ALU, bench)
// ----------------------------------------------------------------------------
interface id_ex_stage_if
    import rv_alu_pkg::*;
#(
    parameter int ILL_CNT_W = 8
);

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic                 flush;

    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           out_alu_cnt;
    logic [XLEN-1:0]      out_r1;
    logic [XLEN-1:0]      out_r2;
    logic [XLEN-1:0]      out_imm;
    logic [3:0]           out_shamt;
    logic [4:0]           out_rd;
    logic                 out_illegal;

    logic [ILL_CNT_W-1:0] ill_count;

    modport slave (
        input  in_valid, in_instr, flush, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_alu_cnt,
               out_r1, out_r2, out_imm, out_shamt, out_rd, out_illegal,
               ill_count
    );

    modport master (
        output in_valid, in_instr, flush, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_alu_cnt,
               out_r1, out_r2, out_imm, out_shamt, out_rd, out_illegal,
               ill_count
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational decode of one RV32 instruction word.
// Ports:
//   instr_i    in   32    instruction word
//   aluCnt_o   out  6     ALU control code, ALU_ILLEGAL when unsupported
//   imm_o      out  XLEN  sign-extended immediate (0 for R-type/illegal)
//   rd_o       out  5     destination register (0 for branch/illegal)
//   shamt_o    out  4     shift amount, instr[23:20]
//   rs1Addr_o  out  5     instr[19:15]
//   rs2Addr_o  out  5     instr[24:20]
//   illegal_o  out  1     instruction is not supported
// ----------------------------------------------------------------------------
module alu_ctrl_decode
    import rv_alu_pkg::*;
(
    input  logic [31:0]     instr_i,
    output logic [5:0]      aluCnt_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o,
    output logic [3:0]      shamt_o,
    output logic [4:0]      rs1Addr_o,
    output logic [4:0]      rs2Addr_o,
    output logic            illegal_o
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic [5:0]   aluCnt;
    instr_class_e cls;

    // Split the instruction word into the fields the decode tables look at
    always_comb begin
        opcode    = instr_i[6:0];
        funct3    = instr_i[14:12];
        funct7b5  = instr_i[30];
        shamt_o   = instr_i[23:20];
        rs1Addr_o = instr_i[19:15];
        rs2Addr_o = instr_i[24:20];
    end

    // Opcode/funct3 table lookup. Every hole in the tables (R and I f3=011,
    // branch f3=010/011/110/111, unknown opcodes) falls through to ALU_ILLEGAL,
    // and the class is forced to CLS_ILL so the immediate and rd stay zero.
    always_comb begin
        aluCnt = ALU_ILLEGAL;
        cls    = CLS_ILL;
        case (opcode)
            OP_R: begin
                cls = CLS_R;
                case (funct3)
                    3'b000:  aluCnt = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b001:  aluCnt = ALU_SLL;
                    3'b010:  aluCnt = ALU_SLT;
                    3'b100:  aluCnt = ALU_XOR;
                    3'b101:  aluCnt = ALU_SRL;
                    3'b110:  aluCnt = ALU_OR;
                    3'b111:  aluCnt = ALU_AND;
                    default: aluCnt = ALU_ILLEGAL;
                endcase
            end
            OP_I: begin
                cls = CLS_I;
                case (funct3)
                    3'b000:  aluCnt = ALU_ADDI;
                    3'b001:  aluCnt = ALU_SLLI;
                    3'b010:  aluCnt = ALU_SLTI;
                    3'b111:  aluCnt = ALU_ANDI;
                    3'b100:  aluCnt = ALU_XORI;
                    3'b101:  aluCnt = ALU_SRLI;
                    3'b110:  aluCnt = ALU_ORI;
                    default: aluCnt = ALU_ILLEGAL;
                endcase
            end
            OP_BR: begin
                cls = CLS_BR;
                case (funct3)
                    3'b000:  aluCnt = ALU_BEQ;
                    3'b001:  aluCnt = ALU_BNE;
                    3'b100:  aluCnt = ALU_BLT;
                    3'b101:  aluCnt = ALU_BGE;
                    default: aluCnt = ALU_ILLEGAL;
                endcase
            end
            default: begin
                aluCnt = ALU_ILLEGAL;
                cls    = CLS_ILL;
            end
        endcase
        if (aluCnt == ALU_ILLEGAL) begin
            cls = CLS_ILL;
        end
    end

    // Immediate and destination register depend only on the instruction class.
    // The branch offset is rebuilt from its scattered fields with an implied
    // zero LSB.
    always_comb begin
        imm_o = '0;
        rd_o  = '0;
        case (cls)
            CLS_R: begin
                rd_o = instr_i[11:7];
            end
            CLS_I: begin
                imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                rd_o  = instr_i[11:7];
            end
            CLS_BR: begin
                imm_o = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            default: begin
                imm_o = '0;
                rd_o  = '0;
            end
        endcase
    end

    assign aluCnt_o  = aluCnt;
    assign illegal_o = (cls == CLS_ILL);

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// Decode/issue stage in front of the ALU. Takes one instruction per
// valid/ready handshake, decodes it, and holds the result in a single-entry
// ID/EX register that feeds the ALU.
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    id_ex_stage_if.slave  handshake, reg-file, ALU-side and status
//                                signals (see id_ex_stage_if)
// ----------------------------------------------------------------------------
module id_ex_stage
    import rv_alu_pkg::*;
#(
    parameter int ILL_CNT_W = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    id_ex_stage_if.slave       bus
);

    logic [5:0]           decAluCnt;
    logic [XLEN-1:0]      decImm;
    logic [4:0]           decRd;
    logic [3:0]           decShamt;
    logic [4:0]           decRs1Addr;
    logic [4:0]           decRs2Addr;
    logic                 decIllegal;

    logic                 inReady;
    logic                 accept;
    idex_t                decoded;

    logic                 outValid_q;
    logic                 outValid_d;
    idex_t                payload_q;
    idex_t                payload_d;
    logic [ILL_CNT_W-1:0] illCount_q;
    logic [ILL_CNT_W-1:0] illCount_d;

    alu_ctrl_decode u_decode (
        .instr_i   (bus.in_instr),
        .aluCnt_o  (decAluCnt),
        .imm_o     (decImm),
        .rd_o      (decRd),
        .shamt_o   (decShamt),
        .rs1Addr_o (decRs1Addr),
        .rs2Addr_o (decRs2Addr),
        .illegal_o (decIllegal)
    );

    // Handshake plus assembly of the entry that would be loaded this cycle.
    // Register x0 always reads as zero, whatever the register file returns.
    always_comb begin
        inReady = !outValid_q || bus.out_ready;
        accept  = bus.in_valid && inReady && !bus.flush;

        decoded         = '0;
        decoded.aluCnt  = decAluCnt;
        decoded.r1      = (decRs1Addr == 5'd0) ? '0 : bus.rs1_data;
        decoded.r2      = (decRs2Addr == 5'd0) ? '0 : bus.rs2_data;
        decoded.imm     = decImm;
        decoded.shamt   = decShamt;
        decoded.rd      = decRd;
        decoded.illegal = decIllegal;
    end

    // Next-state for the ID/EX register and the illegal counter. Flush wins
    // over both accept and stall; a consumed entry with nothing new behind it
    // empties the register. Data is left untouched when not loading so held
    // values stay stable under backpressure.
    always_comb begin
        outValid_d = outValid_q;
        payload_d  = payload_q;
        illCount_d = illCount_q;
        if (bus.flush) begin
            outValid_d = 1'b0;
        end else if (accept) begin
            outValid_d = 1'b1;
            payload_d  = decoded;
            if (decIllegal && (illCount_q != {ILL_CNT_W{1'b1}})) begin
                illCount_d = illCount_q + ILL_CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            payload_q  <= '0;
            illCount_q <= '0;
        end else begin
            outValid_q <= outValid_d;
            payload_q  <= payload_d;
            illCount_q <= illCount_d;
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.rs1_addr    = decRs1Addr;
    assign bus.rs2_addr    = decRs2Addr;
    assign bus.out_valid   = outValid_q;
    assign bus.out_alu_cnt = payload_q.aluCnt;
    assign bus.out_r1      = payload_q.r1;
    assign bus.out_r2      = payload_q.r2;
    assign bus.out_imm     = payload_q.imm;
    assign bus.out_shamt   = payload_q.shamt;
    assign bus.out_rd      = payload_q.rd;
    assign bus.out_illegal = payload_q.illegal;
    assign bus.ill_count   = illCount_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: decode vectors, backpressure, flush,
// illegal counter saturation and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic clk;
    logic rst_n;

    int checkCount;
    int errorCount;
    int expIll;

    id_ex_stage_if #(.ILL_CNT_W(8)) bus ();

    id_ex_stage #(.ILL_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [5:0]  alu;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] r1;
        logic [31:0] r2;
    } vec_t;

    vec_t vecs [9];

    localparam logic [31:0] INSTR_ADD  = 32'h002081B3;
    localparam logic [31:0] INSTR_ADDI = 32'hFFF00093;
    localparam logic [31:0] INSTR_BAD  = 32'h0000007F;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive all inputs, then let the combinational paths settle
    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic fl, input logic rdy);
        bus.in_valid  = valid;
        bus.in_instr  = instr;
        bus.rs1_data  = d1;
        bus.rs2_data  = d2;
        bus.flush     = fl;
        bus.out_ready = rdy;
        #1;
    endtask

    // Advance one clock and sample just after the edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expIll     = 0;

        //                instr          d1        d2        alu    rd    imm           ill   r1        r2
        vecs[0] = '{32'h002081B3, 32'h5,    32'h7,    6'h01, 5'd3, 32'h0,        1'b0, 32'h5,    32'h7};
        vecs[1] = '{32'hFFF00093, 32'hDEAD, 32'h1234, 6'h0B, 5'd1, 32'hFFFFFFFF, 1'b0, 32'h0,    32'h1234};
        vecs[2] = '{32'hFE208EE3, 32'h11,   32'h22,   6'h1B, 5'd0, 32'hFFFFFFFC, 1'b0, 32'h11,   32'h22};
        vecs[3] = '{32'h400302B3, 32'hA5,   32'h99,   6'h02, 5'd5, 32'h0,        1'b0, 32'hA5,   32'h0};
        vecs[4] = '{32'hFE20DEE3, 32'h1,    32'h2,    6'h1E, 5'd0, 32'hFFFFFFFC, 1'b0, 32'h1,    32'h2};
        vecs[5] = '{32'hFE20EEE3, 32'h3,    32'h4,    6'h00, 5'd0, 32'h0,        1'b1, 32'h3,    32'h4};
        vecs[6] = '{32'hFFF07093, 32'h77,   32'h88,   6'h0E, 5'd1, 32'hFFFFFFFF, 1'b0, 32'h0,    32'h88};
        vecs[7] = '{32'h0020B1B3, 32'h9,    32'h10,   6'h00, 5'd0, 32'h0,        1'b1, 32'h9,    32'h10};
        vecs[8] = '{32'h00509113, 32'h40,   32'h50,   6'h0C, 5'd2, 32'h5,        1'b0, 32'h40,   32'h50};

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset_ill",   32'(bus.ill_count), 32'h0);
        checkOutput("reset_alu",   32'(bus.out_alu_cnt), 32'h0);
        checkOutput("reset_r1",    bus.out_r1, 32'h0);
        checkOutput("reset_inrdy", 32'(bus.in_ready), 32'h1);
        #10;
        rst_n = 1'b1;
        stepCycle();

        // Decode vectors, back to back at full throughput
        $display("[TB] decode vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].d1, vecs[i].d2, 1'b0, 1'b1);
            checkOutput($sformatf("v%0d_inrdy", i), 32'(bus.in_ready), 32'h1);
            if (i == 0) begin
                checkOutput("v0_rs1addr", 32'(bus.rs1_addr), 32'd1);
                checkOutput("v0_rs2addr", 32'(bus.rs2_addr), 32'd2);
            end
            stepCycle();
            if (vecs[i].ill) expIll = (expIll == 255) ? 255 : expIll + 1;
            checkOutput($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'h1);
            checkOutput($sformatf("v%0d_alu", i),   32'(bus.out_alu_cnt), 32'(vecs[i].alu));
            checkOutput($sformatf("v%0d_rd", i),    32'(bus.out_rd), 32'(vecs[i].rd));
            checkOutput($sformatf("v%0d_ill", i),   32'(bus.out_illegal), 32'(vecs[i].ill));
            checkOutput($sformatf("v%0d_r1", i),    bus.out_r1, vecs[i].r1);
            checkOutput($sformatf("v%0d_r2", i),    bus.out_r2, vecs[i].r2);
            if (!vecs[i].ill) begin
                checkOutput($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
            end
            checkOutput($sformatf("v%0d_cnt", i),   32'(bus.ill_count), 32'(expIll));
        end
        checkOutput("v8_shamt", 32'(bus.out_shamt), 32'h5);

        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("drain_valid", 32'(bus.out_valid), 32'h0);

        // Backpressure: A held for three stalled cycles, then B goes in
        $display("[TB] backpressure");
        applyStimulus(1'b1, INSTR_ADD, 32'h5, 32'h7, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bp_a_valid", 32'(bus.out_valid), 32'h1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, INSTR_ADDI, 32'hDEAD, 32'h0, 1'b0, 1'b0);
            checkOutput($sformatf("bp%0d_inrdy", k), 32'(bus.in_ready), 32'h0);
            stepCycle();
            checkOutput($sformatf("bp%0d_valid", k), 32'(bus.out_valid), 32'h1);
            checkOutput($sformatf("bp%0d_alu", k),   32'(bus.out_alu_cnt), 32'h01);
            checkOutput($sformatf("bp%0d_r1", k),    bus.out_r1, 32'h5);
            checkOutput($sformatf("bp%0d_r2", k),    bus.out_r2, 32'h7);
        end
        applyStimulus(1'b1, INSTR_ADDI, 32'hDEAD, 32'h0, 1'b0, 1'b1);
        checkOutput("bp_b_inrdy", 32'(bus.in_ready), 32'h1);
        stepCycle();
        checkOutput("bp_b_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("bp_b_alu",   32'(bus.out_alu_cnt), 32'h0B);
        checkOutput("bp_b_r1",    bus.out_r1, 32'h0);
        checkOutput("bp_b_imm",   bus.out_imm, 32'hFFFFFFFF);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("bp_drain", 32'(bus.out_valid), 32'h0);

        // Flush with a held entry and an incoming illegal op
        $display("[TB] flush");
        applyStimulus(1'b1, INSTR_ADD, 32'h5, 32'h7, 1'b0, 1'b0);
        stepCycle();
        checkOutput("fl_held", 32'(bus.out_valid), 32'h1);
        applyStimulus(1'b1, INSTR_BAD, 32'h0, 32'h0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("fl_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("fl_cnt",   32'(bus.ill_count), 32'(expIll));
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("fl_after", 32'(bus.out_valid), 32'h0);

        // Illegal stream, counter must stop at all-ones
        $display("[TB] illegal saturation");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, INSTR_BAD, 32'h0, 32'h0, 1'b0, 1'b1);
            stepCycle();
            expIll = (expIll == 255) ? 255 : expIll + 1;
            if (i == 0) begin
                checkOutput("sat_ill", 32'(bus.out_illegal), 32'h1);
                checkOutput("sat_alu", 32'(bus.out_alu_cnt), 32'h0);
                checkOutput("sat_cnt_first", 32'(bus.ill_count), 32'(expIll));
            end
            if (i == 251 || i == 252 || i == 299) begin
                checkOutput($sformatf("sat_cnt_%0d", i), 32'(bus.ill_count), 32'(expIll));
            end
        end
        checkOutput("sat_cnt_final", 32'(bus.ill_count), 32'd255);

        // Asynchronous reset while stalled
        $display("[TB] async reset");
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("ar_held", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("ar_cnt",   32'(bus.ill_count), 32'h0);
        checkOutput("ar_ill",   32'(bus.out_illegal), 32'h0);
        #10;
        rst_n = 1'b1;
        stepCycle();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
